icon_overlay_ctrl: RTL and testbench

- Raster-side controller directly upstream of the icon ROM lookup stage.
- Converts the VGA scan position into an icon number and a 13-bit linear pixel address (0..6399 inside an 80x80 icon). The lookup stage turns these into a 16-bit ROM word address and returns icon RGB.
- Delays the background RGB to match ROM latency, then multiplexes icon or background pixels onto the VGA output.
- Icon position and number are double-buffered so a change never tears mid-frame.

---
 rtl/icon_pkg.sv | 20 ++
 rtl/icon_delay_line.sv | 28 ++
 rtl/icon_overlay_ctrl.sv | 165 ++++++++++++++++
 tb/tb_icon_overlay_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/icon_pkg.sv
// Shared geometry, key colour and state encoding for the icon overlay path.
// Pure declarations, no logic.
// Optional ICON_TRANSPARENT_EN build uses KEY_COLOR as the see-through pixel.
package icon_pkg;

  localparam int ICON_W         = 80;
  localparam int ICON_H         = 80;
  localparam int ICON_PIXELS    = 6400;
  localparam int WORDS_PER_ICON = 3200;
  localparam int H_ACT          = 640;
  localparam int V_ACT          = 480;

  localparam logic [23:0] KEY_COLOR = 24'h000000;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

endpackage

// File: rtl/icon_delay_line.sv
// Fixed-depth shift register used to align side-band data with the ROM lookup.
// Latency: DEPTH cycles; one word in and one word out every clock.
// No backpressure: the line advances unconditionally and is cleared by rst.
module icon_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift every stage by one each clock; reset flushes the whole line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/icon_overlay_ctrl.sv
// Maps raster position to icon number/pixel address and composites icon over background.
// Latency: ROM_LAT+2 cycles from iRequest to oValid, one pixel per clock.
// No backpressure; ICON_TRANSPARENT_EN makes KEY_COLOR icon pixels show the background.
module icon_overlay_ctrl
  import icon_pkg::*;
#(
  parameter int ROM_LAT   = 1,
  parameter int NUM_ICONS = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRequest,
  input  logic [9:0]  iVGA_X,
  input  logic [9:0]  iVGA_Y,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  input  logic        iLoad,
  input  logic        iEnable,
  input  logic [9:0]  iPos_X,
  input  logic [9:0]  iPos_Y,
  input  logic [3:0]  iNumber,
  output logic [3:0]  oNumber,
  output logic [12:0] oAddress,
  input  logic [7:0]  iIconRed,
  input  logic [7:0]  iIconGreen,
  input  logic [7:0]  iIconBlue,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oValid,
  output logic        oActive
);

  localparam int          DLY      = 1 + ROM_LAT;
  localparam logic [12:0] ROW_STEP = 13'(ICON_W);
  localparam logic [12:0] ROW_MAX  = 13'(ICON_PIXELS - ICON_W);
  localparam logic [10:0] W_SPAN   = 11'(ICON_W - 1);
  localparam logic [10:0] H_SPAN   = 11'(ICON_H - 1);
  localparam logic [9:0]  X_LAST   = 10'(H_ACT - 1);
  localparam logic [4:0]  NUM_LIM  = 5'(NUM_ICONS);

  // shadow (written by iLoad) and live (used for drawing) register sets
  logic        sh_en;
  logic [9:0]  sh_px, sh_py;
  logic [3:0]  sh_num;
  state_t      state;
  logic [9:0]  lv_px, lv_py;
  logic [3:0]  lv_num;
  logic [12:0] row_base;

  // At frame start the shadow values take effect for that very pixel, so the
  // window test looks through to the shadow set in that cycle.
  logic        frame_start;
  state_t      cur_state;
  logic [9:0]  cur_px, cur_py;
  logic [3:0]  cur_num;
  logic [12:0] cur_row_base;
  logic        in_cols, in_rows, in_win, row_end;
  logic [6:0]  col;

  assign frame_start  = iRequest && (iVGA_X == 10'd0) && (iVGA_Y == 10'd0);
  assign cur_state    = frame_start ? (sh_en ? DRAW : IDLE) : state;
  assign cur_px       = frame_start ? sh_px  : lv_px;
  assign cur_py       = frame_start ? sh_py  : lv_py;
  assign cur_num      = frame_start ? sh_num : lv_num;
  assign cur_row_base = frame_start ? 13'd0  : row_base;

  // 11-bit compares so pos+79 never wraps past 1023
  assign in_cols = ({1'b0, iVGA_X} >= {1'b0, cur_px}) && ({1'b0, iVGA_X} <= {1'b0, cur_px} + W_SPAN);
  assign in_rows = ({1'b0, iVGA_Y} >= {1'b0, cur_py}) && ({1'b0, iVGA_Y} <= {1'b0, cur_py} + H_SPAN);
  assign in_win  = (cur_state == DRAW) && iRequest && in_cols && in_rows;
  assign row_end = iRequest && (iVGA_X == X_LAST) && in_rows;
  // only the low 7 bits of x - pos_x matter inside an 80-wide window
  assign col     = iVGA_X[6:0] - cur_px[6:0];

  // Capture shadow settings; out-of-range icon numbers are ignored.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sh_en  <= 1'b0;
      sh_px  <= '0;
      sh_py  <= '0;
      sh_num <= '0;
    end else if (iLoad) begin
      sh_en <= iEnable;
      sh_px <= iPos_X;
      sh_py <= iPos_Y;
      if ({1'b0, iNumber} < NUM_LIM) sh_num <= iNumber;
    end
  end

  // Promote shadow to live and choose the frame's state, only at frame start.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      lv_px  <= '0;
      lv_py  <= '0;
      lv_num <= '0;
    end else if (frame_start) begin
      state  <= sh_en ? DRAW : IDLE;
      lv_px  <= sh_px;
      lv_py  <= sh_py;
      lv_num <= sh_num;
    end
  end

  // Advance the row base at the end of each window row, even when clipped on the right.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      row_base <= '0;
    end else if (frame_start) begin
      row_base <= '0;
    end else if (row_end && (row_base < ROW_MAX)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Lookup-stage request registers; the address holds outside the window.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oNumber  <= '0;
      oAddress <= '0;
    end else begin
      oNumber <= cur_num;
      if (in_win) oAddress <= cur_row_base + {6'd0, col};
    end
  end

  // Side-band delays matching the address register plus ROM latency
  logic        req_d, win_d;
  logic [23:0] bg_d;

  icon_delay_line #(.WIDTH(1), .DEPTH(DLY)) u_req_dly (
    .clk(iCLK), .rst(iRST), .din(iRequest), .dout(req_d)
  );
  icon_delay_line #(.WIDTH(1), .DEPTH(DLY)) u_win_dly (
    .clk(iCLK), .rst(iRST), .din(in_win), .dout(win_d)
  );
  icon_delay_line #(.WIDTH(24), .DEPTH(DLY)) u_bg_dly (
    .clk(iCLK), .rst(iRST), .din({iRed, iGreen, iBlue}), .dout(bg_d)
  );

  logic [23:0] icon_pix;
  logic        use_icon;
  assign icon_pix = {iIconRed, iIconGreen, iIconBlue};
`ifdef ICON_TRANSPARENT_EN
  assign use_icon = win_d && (icon_pix != KEY_COLOR);
`else
  assign use_icon = win_d;
`endif

  // Composite output; RGB holds across cycles without a request.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oValid <= 1'b0;
      {oRed, oGreen, oBlue} <= '0;
    end else begin
      oValid <= req_d;
      if (req_d) {oRed, oGreen, oBlue} <= use_icon ? icon_pix : bg_d;
    end
  end

  assign oActive = (state == DRAW);

endmodule

// File: tb/tb_icon_overlay_ctrl.sv
// Self-checking bench for icon_overlay_ctrl: behavioural model plus pixel scoreboard.
// Lookup stage is modelled as a one-cycle ROM returning a pattern derived from number/address.
// Build with ICON_TRANSPARENT_EN to exercise the key-colour path.
module tb_icon_overlay_ctrl;

  localparam int ROM_LAT = 1;
  localparam int LAT     = ROM_LAT + 2;
`ifdef ICON_TRANSPARENT_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iRequest = 1'b0, iLoad = 1'b0, iEnable = 1'b0;
  logic [9:0]  iVGA_X = '0, iVGA_Y = '0, iPos_X = '0, iPos_Y = '0;
  logic [7:0]  iRed = '0, iGreen = '0, iBlue = '0;
  logic [3:0]  iNumber = '0;
  logic [3:0]  oNumber;
  logic [12:0] oAddress;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        oValid, oActive;
  logic [23:0] rom_q = '0;

  always #5 clk = ~clk;

  icon_overlay_ctrl #(.ROM_LAT(ROM_LAT), .NUM_ICONS(10)) dut (
    .iCLK(clk), .iRST(rst), .iRequest(iRequest), .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iLoad(iLoad), .iEnable(iEnable),
    .iPos_X(iPos_X), .iPos_Y(iPos_Y), .iNumber(iNumber), .oNumber(oNumber),
    .oAddress(oAddress), .iIconRed(rom_q[23:16]), .iIconGreen(rom_q[15:8]),
    .iIconBlue(rom_q[7:0]), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oValid(oValid), .oActive(oActive)
  );

  function automatic logic [23:0] rom_f(input logic [3:0] n, input logic [12:0] a);
    return {n, 7'd0, a};
  endfunction

  always @(posedge clk) rom_q <= rom_f(oNumber, oAddress);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int stamp; logic [23:0] rgb; } sb_t;
  sb_t sb[$];
  logic [23:0] last_rgb = '0;

  // Output monitor: each valid pixel must match the oldest expectation, LAT cycles on.
  always @(negedge clk) begin : mon
    sb_t e;
    if (oValid) begin
      if (sb.size() == 0) begin
        check("unexpected valid", 32'(oValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel latency", 32'(cyc), 32'(e.stamp + LAT));
        check("pixel rgb", {8'd0, oRed, oGreen, oBlue}, {8'd0, e.rgb});
        last_rgb = e.rgb;
      end
    end else begin
      if (sb.size() > 0 && sb[0].stamp + LAT <= cyc) begin
        e = sb.pop_front();
        check("missing valid", 32'(oValid), 32'd1);
      end
      check("rgb hold", {8'd0, oRed, oGreen, oBlue}, {8'd0, last_rgb});
    end
  end

  typedef struct { int frame; int x; int y; logic [12:0] addr; logic [3:0] num; } probe_t;
  probe_t probes[13];

  // behavioural model state
  int sh_en = 0, sh_px = 0, sh_py = 0, sh_num = 0;
  int lv_draw = 0, lv_px = 0, lv_py = 0, lv_num = 0;
  int m_addr = 0, frm = 0;

  task automatic step(input bit req, input int x, input int y, input bit ld = 1'b0,
                      input int en = 0, input int px = 0, input int py = 0, input int num = 0);
    bit fs, win;
    int addr;
    logic [23:0] bg, icon;
    fs = req && x == 0 && y == 0;
    if (fs) begin
      lv_draw = sh_en; lv_px = sh_px; lv_py = sh_py; lv_num = sh_num; frm++;
    end
    win  = (lv_draw != 0) && req && x >= lv_px && x <= lv_px + 79 && y >= lv_py && y <= lv_py + 79;
    addr = (y - lv_py) * 80 + (x - lv_px);
    bg   = {8'hF0 | 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom)};
    icon = rom_f(4'(lv_num), 13'(addr));
    if (req) sb.push_back('{cyc, (win && !(TRANS && icon == 24'h0)) ? icon : bg});
    if (ld) begin
      sh_en = en; sh_px = px; sh_py = py;
      if (num < 10) sh_num = num;
    end
    iRequest = req; iVGA_X = 10'(x); iVGA_Y = 10'(y);
    {iRed, iGreen, iBlue} = bg;
    iLoad = ld; iEnable = en[0]; iPos_X = 10'(px); iPos_Y = 10'(py); iNumber = 4'(num);
    @(posedge clk); #1;
    if (win) m_addr = addr;
    check("address", 32'(oAddress), 32'(m_addr));
    check("number", 32'(oNumber), 32'(lv_num));
    check("active", 32'(oActive), 32'(lv_draw));
    for (int i = 0; i < 13; i++) begin
      if (req && probes[i].frame == frm && probes[i].x == x && probes[i].y == y) begin
        hits++;
        check("probe address", 32'(oAddress), 32'(probes[i].addr));
        check("probe number", 32'(oNumber), 32'(probes[i].num));
      end
    end
  endtask

  // Drive the interesting columns of each row, always ending on column 639.
  task automatic run_rows(input int y0, input int y1, input int px);
    int xs[6];
    xs = '{px - 1, px, px + 1, px + 40, px + 79, px + 80};
    for (int y = y0; y <= y1; y++) begin
      for (int i = 0; i < 6; i++)
        if (xs[i] >= 0 && xs[i] < 639 && !(xs[i] == 0 && y == 0)) step(1'b1, xs[i], y);
      step(1'b1, 639, y);
      step(1'b0, 0, 0);
    end
  endtask

  task automatic rst_pulse();
    iRequest = 1'b0; iLoad = 1'b0;
    rst = 1'b1;
    sb.delete();
    sh_en = 0; sh_px = 0; sh_py = 0; sh_num = 0;
    lv_draw = 0; lv_px = 0; lv_py = 0; lv_num = 0; m_addr = 0;
    last_rgb = '0;
    #1;
    check("rst address", 32'(oAddress), 32'd0);
    check("rst number", 32'(oNumber), 32'd0);
    check("rst valid", 32'(oValid), 32'd0);
    check("rst active", 32'(oActive), 32'd0);
    check("rst rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    probes[0]  = '{1, 100,  50,    0, 2};
    probes[1]  = '{1, 179,  50,   79, 2};
    probes[2]  = '{1, 100,  51,   80, 2};
    probes[3]  = '{1, 179, 129, 6399, 2};
    probes[4]  = '{2, 639,  10,   39, 2};
    probes[5]  = '{2, 600,  11,   80, 2};
    probes[6]  = '{2, 639,  89, 6359, 2};
    probes[7]  = '{3,   0,   0,    0, 5};
    probes[8]  = '{3,  79,  79, 6399, 5};
    probes[9]  = '{4, 101,  50,    1, 0};
    probes[10] = '{4, 140,  79, 2360, 0};
    probes[11] = '{5,  10,  10,    0, 3};
    probes[12] = '{6,  20,  20,    0, 7};

    repeat (2) @(posedge clk);
    #1;
    check("reset address", 32'(oAddress), 32'd0);
    check("reset number", 32'(oNumber), 32'd0);
    check("reset valid", 32'(oValid), 32'd0);
    check("reset active", 32'(oActive), 32'd0);
    check("reset rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
    rst = 1'b0;
    step(1'b0, 0, 0);

    // frame 1: icon 2 at (100,50); mid-frame load of a bad number and a new position
    step(1'b0, 0, 0, 1'b1, 1, 100, 50, 2);
    step(1'b1, 0, 0);
    run_rows(49, 60, 100);
    step(1'b0, 0, 0, 1'b1, 1, 600, 10, 12);
    run_rows(61, 130, 100);

    // frame 2: right-clipped at (600,10), still icon 2; load (0,0)/5 during row 200
    step(1'b1, 0, 0);
    run_rows(9, 90, 600);
    step(1'b1, 300, 200, 1'b1, 1, 0, 0, 5);
    step(1'b1, 300, 201);
    step(1'b1, 639, 201);

    // frame 3: icon 5 at the origin
    step(1'b1, 0, 0);
    run_rows(0, 80, 0);
    step(1'b0, 0, 0, 1'b1, 1, 100, 50, 0);

    // frame 4: icon 0 at (100,50), aborted by reset inside the window
    step(1'b1, 0, 0);
    run_rows(49, 79, 100);
    step(1'b1, 99, 80);
    step(1'b1, 100, 80);
    step(1'b1, 150, 80);
    rst_pulse();
    run_rows(81, 85, 100);
    step(1'b0, 0, 0, 1'b1, 1, 10, 10, 3);

    // frame 5: load coincident with frame start applies only to frame 6
    step(1'b1, 0, 0, 1'b1, 1, 20, 20, 7);
    run_rows(9, 11, 10);

    // frame 6
    step(1'b1, 0, 0);
    run_rows(19, 21, 20);

    repeat (LAT + 3) step(1'b0, 0, 0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    check("probe hits", 32'(hits), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
